fp_mul_stream: RTL and testbench

Streaming front-end for the combinational `FP_Multiplier`. It accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and buffers them in a small FIFO. The FIFO head drives the multiplier inputs. Each product is captured into a registered output stage with a valid/ready handshake and special-value flags, so the combinational multiplier can sit between pipelined producers and consumers.

---
 rtl/fp_mul_stream.sv | 81 ++++++++
 tb/tb_fp_mul_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_stream.sv
// Streaming wrapper around a combinational single-precision multiplier: operand FIFO in front,
// registered result stage with special-value flags behind, valid/ready on both sides.
module fp_mul_stream #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_a,
   input  logic [31:0]                in_b,
   output logic [31:0]                mul_a,
   output logic [31:0]                mul_b,
   input  logic [31:0]                mul_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_result,
   output logic [2:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   storage [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // {nan, inf, zero}; the three cases are mutually exclusive by construction.
   function automatic logic [2:0] flags_of(input logic [31:0] r);
      logic [7:0]  e;
      logic [22:0] m;
      e = r[30:23];
      m = r[22:0];
      flags_of = {(e == 8'hFF) && (m != '0),
                  (e == 8'hFF) && (m == '0),
                  (e == 8'h00) && (m == '0)};
   endfunction

   // Ready depends on occupancy only, so a full FIFO never accepts on a same-cycle pop.
   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count != '0) && (!out_valid || out_ready);

   assign mul_a = storage[rd_ptr][63:32];
   assign mul_b = storage[rd_ptr][31:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         // NOTE: storage is reset too, so the multiplier sees zeros instead of stale operands.
         for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= {in_a, in_b};
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            out_result <= mul_result;
            out_flags  <= flags_of(mul_result);
            out_valid  <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_stream.sv
// Bench for fp_mul_stream: a stand-in multiplier drives mul_result, and a queue-based model
// predicts occupancy, readiness and the ordered result stream.
module tb_fp_mul_stream;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [31:0] mul_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [2:0]  out_flags;
   logic [$clog2(DEPTH):0] count;

   int n_pass = 0;
   int n_total = 0;

   logic        stub_force = 1'b0;
   logic [31:0] stub_val = '0;

   typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
   pair_t       q[$];
   logic        m_has = 1'b0;
   logic [31:0] m_res = '0;
   int          max_count = 0;

   fp_mul_stream #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .count(count)
   );

   always #5 clk = ~clk;

   // Stand-in multiplier: exact for the directed vectors, an arbitrary mix otherwise.
   function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000) return b;
      if (b == 32'h3F80_0000) return a;
      if (a == 32'h4040_0000 && b == 32'h4080_0000) return 32'h4140_0000;
      return (a * 32'd2654435761) ^ {b[15:0], b[31:16]};
   endfunction

   function automatic logic [31:0] product(input pair_t p);
      return stub_force ? stub_val : fake_mul(p.a, p.b);
   endfunction

   function automatic logic [2:0] ref_flags(input logic [31:0] r);
      int e;
      int m;
      e = int'(r[30:23]);
      m = int'(r[22:0]);
      return {(e == 255 && m != 0), (e == 255 && m == 0), (e == 0 && m == 0)};
   endfunction

   always_comb mul_result = stub_force ? stub_val : fake_mul(mul_a, mul_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_state();
      check("count", 32'(count), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(m_has));
      if (m_has) begin
         check("out_result", out_result, m_res);
         check("out_flags", 32'(out_flags), 32'(ref_flags(m_res)));
      end
      if (q.size() > 0) begin
         check("mul_a", mul_a, q[0].a);
         check("mul_b", mul_b, q[0].b);
      end
   endtask

   // One clock: drive at the falling edge, check, then advance the model across the rising edge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, output logic acc);
      logic  m_push;
      logic  m_pop;
      pair_t p;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      #1;
      check_state();
      acc    = v && in_ready;
      m_push = v && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && (!m_has || ordy);
      @(posedge clk);
      if (m_pop) begin
         p     = q.pop_front();
         m_res = product(p);
         m_has = 1'b1;
      end else if (m_has && ordy) begin
         m_has = 1'b0;
      end
      if (m_push) begin
         p.a = a;
         p.b = b;
         q.push_back(p);
      end
      if (q.size() > max_count) max_count = q.size();
      @(negedge clk);
   endtask

   logic        acc;
   int          n_acc;
   logic [31:0] flag_vals [4] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
   logic [2:0]  flag_exp  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mul_a", mul_a, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic
      check("basic_in_ready", 32'(in_ready), 32'd1);
      check("basic_out_result", out_result, 32'd0);
      check("basic_out_flags", 32'(out_flags), 32'd0);
      check("basic_mul_b", mul_b, 32'd0);
      cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, acc);
      check("basic_mul_a_after1", mul_a, 32'h3F80_0000);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
      check("basic_result", out_result, 32'h4000_0000);
      check("basic_valid", 32'(out_valid), 32'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);

      // Back-to-back
      cycle(1'b1, 32'h4040_0000, 32'h4080_0000, 1'b1, acc);
      cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, acc);
      check("b2b_first", out_result, 32'h4140_0000);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
      check("b2b_second", out_result, 32'h3F80_0000);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);

      // Backpressure: 6 offers against a stalled consumer
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 1'b0, acc);
         if (acc) n_acc++;
      end
      check("bp_accepted", 32'(n_acc), 32'd5);
      check("bp_count", 32'(count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);

      // Wrap-around with toggling consumer
      max_count = 0;
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'h4100_0000 + 32'(i * 7), 32'h3000_0000 + 32'(i), 1'(i % 2 == 0), acc);
      repeat (12) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
      check("wrap_max_count_le_depth", 32'(max_count <= DEPTH), 32'd1);

      // Flags from forced multiplier results
      stub_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stub_val = flag_vals[i];
         cycle(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc);
         cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
         check("flags_dir", 32'(out_flags), 32'(flag_exp[i]));
         cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
      end
      stub_force = 1'b0;

      // Reset mid-stream: one held result plus 3 queued
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i), 1'b0, acc);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, acc);
      check("pre_rst_count", 32'(count), 32'd3);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_result", out_result, 32'd0);
      check("mid_rst_flags", 32'(out_flags), 32'd0);
      check("mid_rst_mul_a", mul_a, 32'd0);
      q.delete();
      m_has = 1'b0;
      m_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);

      // Randomized traffic
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0), acc);
      repeat (8) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
